// File: rtl/decode_stage.sv
// decode_stage: classifies incoming ARM-subset instructions, buffers them in a
// small FIFO and evaluates each head entry's condition against the NZCV flags
// as it leaves the stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on the registered count. out_valid and the head
// fields depend only on registered state. out_exec can follow flag_nzcv
// combinationally when FLAG_FWD=1. A producer must hold its payload stable
// while valid is high and ready is low.
module decode_stage #(
  parameter int BUF_DEPTH  = 2,
  parameter int REG_ADDR_W = 4,
  parameter bit FLAG_FWD   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [31:0]           in_pc,
  input  logic                  flush,
  input  logic                  flag_we,
  input  logic [3:0]            flag_nzcv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_ADDR_W-1:0] out_rn,
  output logic [REG_ADDR_W-1:0] out_rm,
  output logic [2:0]            out_class,
  output logic                  out_load,
  output logic                  out_write_en,
  output logic                  out_exec,
  output logic [23:0]           out_imm24,
  output logic [3:0]            flags
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  // FIFO storage, one array per stored field
  logic [31:0]           r_pc    [BUF_DEPTH];
  logic [3:0]            r_cond  [BUF_DEPTH];
  logic [REG_ADDR_W-1:0] r_rd    [BUF_DEPTH];
  logic [REG_ADDR_W-1:0] r_rn    [BUF_DEPTH];
  logic [REG_ADDR_W-1:0] r_rm    [BUF_DEPTH];
  logic [2:0]            r_class [BUF_DEPTH];
  logic                  r_load  [BUF_DEPTH];
  logic                  r_we    [BUF_DEPTH];
  logic [23:0]           r_imm   [BUF_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_flags;

  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_class;
  logic                  w_load;
  logic                  w_we;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [3:0]            w_eff;
  logic [3:0]            w_cond;
  logic                  w_n, w_z, w_c, w_v;

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  // flush wins: nothing enters or leaves the queue on a flushing edge
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // Classify and decode the incoming word before it is stored
  always_comb begin
    w_class = 3'b000;
    w_load  = 1'b0;
    w_we    = 1'b0;
    w_rd    = REG_ADDR_W'(in_inst[15:12]);
    case (in_inst[27:25])
      3'b000, 3'b001: begin
        w_class = 3'b001;
        // TST/TEQ/CMP/CMN only set flags
        w_we    = ~((in_inst[24:23] == 2'b10) & in_inst[20]);
      end
      3'b010, 3'b011: begin
        w_class = 3'b010;
        w_load  = in_inst[20];
        w_we    = in_inst[20];
      end
      3'b101: begin
        w_class = 3'b100;
        w_we    = in_inst[24];
        if (in_inst[24]) begin
          w_rd = REG_ADDR_W'(4'd14);
        end
      end
      default: begin
        w_class = 3'b000;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping; flush returns to the reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write decoded entry at the tail; storage is zeroed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_cond[i]  <= '0;
        r_rd[i]    <= '0;
        r_rn[i]    <= '0;
        r_rm[i]    <= '0;
        r_class[i] <= '0;
        r_load[i]  <= 1'b0;
        r_we[i]    <= 1'b0;
        r_imm[i]   <= '0;
      end
    end else if (w_push) begin
      r_pc[r_wr_ptr]    <= in_pc;
      r_cond[r_wr_ptr]  <= in_inst[31:28];
      r_rd[r_wr_ptr]    <= w_rd;
      r_rn[r_wr_ptr]    <= REG_ADDR_W'(in_inst[19:16]);
      r_rm[r_wr_ptr]    <= REG_ADDR_W'(in_inst[3:0]);
      r_class[r_wr_ptr] <= w_class;
      r_load[r_wr_ptr]  <= w_load;
      r_we[r_wr_ptr]    <= w_we;
      r_imm[r_wr_ptr]   <= in_inst[23:0];
    end
  end

  // NZCV register; flush deliberately leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (flag_we) begin
      r_flags <= flag_nzcv;
    end
  end

  assign flags        = r_flags;
  assign out_pc       = r_pc[r_rd_ptr];
  assign out_rd       = r_rd[r_rd_ptr];
  assign out_rn       = r_rn[r_rd_ptr];
  assign out_rm       = r_rm[r_rd_ptr];
  assign out_class    = r_class[r_rd_ptr];
  assign out_load     = r_load[r_rd_ptr];
  assign out_write_en = r_we[r_rd_ptr];
  assign out_imm24    = r_imm[r_rd_ptr];
  assign w_cond       = r_cond[r_rd_ptr];

  assign w_eff = (FLAG_FWD && flag_we) ? flag_nzcv : r_flags;
  assign w_n   = w_eff[3];
  assign w_z   = w_eff[2];
  assign w_c   = w_eff[1];
  assign w_v   = w_eff[0];

  // Condition check of the head entry against the effective flags
  always_comb begin
    out_exec = 1'b0;
    case (w_cond)
      4'h0: out_exec = w_z;
      4'h1: out_exec = ~w_z;
      4'h2: out_exec = w_c;
      4'h3: out_exec = ~w_c;
      4'h4: out_exec = w_n;
      4'h5: out_exec = ~w_n;
      4'h6: out_exec = w_v;
      4'h7: out_exec = ~w_v;
      4'h8: out_exec = w_c & ~w_z;
      4'h9: out_exec = ~w_c | w_z;
      4'hA: out_exec = (w_n == w_v);
      4'hB: out_exec = (w_n != w_v);
      4'hC: out_exec = ~w_z & (w_n == w_v);
      4'hD: out_exec = w_z | (w_n != w_v);
      4'hE: out_exec = 1'b1;
      default: out_exec = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed stimulus for decode_stage with a queue-based
// reference model checked on every falling edge, plus literal spot checks.
module tb_decode_stage;

  localparam int BUF_DEPTH  = 2;
  localparam int REG_ADDR_W = 4;
  localparam bit FLAG_FWD   = 1'b1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [31:0]           in_inst = '0;
  logic [31:0]           in_pc = '0;
  logic                  flush = 1'b0;
  logic                  flag_we = 1'b0;
  logic [3:0]            flag_nzcv = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [31:0]           out_pc;
  logic [REG_ADDR_W-1:0] out_rd, out_rn, out_rm;
  logic [2:0]            out_class;
  logic                  out_load, out_write_en, out_exec;
  logic [23:0]           out_imm24;
  logic [3:0]            flags;

  int vectors = 0;
  int miscompares = 0;

  // model state: each entry is {pc, inst}
  logic [63:0] exp_q[$];
  logic [3:0]  m_flags = 4'b0000;

  decode_stage #(
    .BUF_DEPTH(BUF_DEPTH), .REG_ADDR_W(REG_ADDR_W), .FLAG_FWD(FLAG_FWD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .flag_we(flag_we),
    .flag_nzcv(flag_nzcv), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rn(out_rn), .out_rm(out_rm),
    .out_class(out_class), .out_load(out_load), .out_write_en(out_write_en),
    .out_exec(out_exec), .out_imm24(out_imm24), .flags(flags)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model (from instruction-set rules) ----
  function automatic logic [2:0] m_class(input logic [31:0] i);
    if (i[27:26] == 2'b00)  return 3'b001;
    if (i[27:26] == 2'b01)  return 3'b010;
    if (i[27:25] == 3'b101) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic m_we(input logic [31:0] i);
    logic [2:0] c;
    int op;
    c  = m_class(i);
    op = int'(i[24:21]);
    if (c == 3'b001) return !(op >= 8 && op <= 11 && i[20]);
    if (c == 3'b010) return i[20];
    if (c == 3'b100) return i[24];
    return 1'b0;
  endfunction

  function automatic logic m_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // compare against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    logic [31:0] hi, hp;
    logic [3:0]  eff;
    logic [31:0] erd;
    logic        acc, pop;
    if (rst) begin
      exp_q.delete();
      m_flags = 4'b0000;
    end
    chk("m_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("m_in_ready", 32'(in_ready), 32'(exp_q.size() < BUF_DEPTH));
    chk("m_flags", 32'(flags), 32'(m_flags));
    if (exp_q.size() != 0) begin
      {hp, hi} = exp_q[0];
      eff = (FLAG_FWD && flag_we) ? flag_nzcv : m_flags;
      erd = (m_class(hi) == 3'b100 && hi[24]) ? 32'd14 : 32'(hi[15:12]);
      chk("m_pc", out_pc, hp);
      chk("m_class", 32'(out_class), 32'(m_class(hi)));
      chk("m_rd", 32'(out_rd), erd);
      chk("m_rn", 32'(out_rn), 32'(hi[19:16]));
      chk("m_rm", 32'(out_rm), 32'(hi[3:0]));
      chk("m_load", 32'(out_load), 32'(m_class(hi) == 3'b010 && hi[20]));
      chk("m_write_en", 32'(out_write_en), 32'(m_we(hi)));
      chk("m_imm24", 32'(out_imm24), 32'(hi[23:0]));
      chk("m_exec", 32'(out_exec), 32'(m_pass(hi[31:28], eff)));
    end
    if (!rst) begin
      acc = in_valid && (exp_q.size() < BUF_DEPTH);
      pop = (exp_q.size() != 0) && out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({in_pc, in_inst});
      end
      if (flag_we) m_flags = flag_nzcv;
    end
  end

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    // reset
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_out_pc", out_pc, 0);

    // ADD r1,r2,r3
    offer(32'hE0821003, 32'h100);
    step();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 1);
    chk("add_class", 32'(out_class), 3'b001);
    chk("add_rd", 32'(out_rd), 1);
    chk("add_rn", 32'(out_rn), 2);
    chk("add_rm", 32'(out_rm), 3);
    chk("add_we", 32'(out_write_en), 1);
    chk("add_exec", 32'(out_exec), 1);
    pop_one();

    // CMP r1,r2 then LDR r0,[r1]
    offer(32'hE1510002, 32'h104);
    step();
    offer(32'hE5910000, 32'h108);
    step();
    in_valid = 1'b0;
    chk("cmp_class", 32'(out_class), 3'b001);
    chk("cmp_we", 32'(out_write_en), 0);
    pop_one();
    chk("ldr_class", 32'(out_class), 3'b010);
    chk("ldr_load", 32'(out_load), 1);
    chk("ldr_rd", 32'(out_rd), 0);
    chk("ldr_rn", 32'(out_rn), 1);
    chk("ldr_we", 32'(out_write_en), 1);
    pop_one();

    // BL
    offer(32'hEB000004, 32'h10C);
    step();
    in_valid = 1'b0;
    chk("bl_class", 32'(out_class), 3'b100);
    chk("bl_rd", 32'(out_rd), 14);
    chk("bl_we", 32'(out_write_en), 1);
    chk("bl_imm24", 32'(out_imm24), 32'h000004);
    pop_one();

    // BEQ held at the head while Z gets set
    offer(32'h0A000000, 32'h110);
    step();
    in_valid = 1'b0;
    chk("beq_exec_z0", 32'(out_exec), 0);
    flag_we   = 1'b1;
    flag_nzcv = 4'b0100;
    #1;
    chk("beq_exec_fwd", 32'(out_exec), 1);
    step();
    flag_we = 1'b0;
    chk("beq_flags", 32'(flags), 4'b0100);
    chk("beq_exec_reg", 32'(out_exec), 1);
    pop_one();

    // fill, hold a third offer, pop with it held, wrap pointers
    offer(32'hE0821003, 32'h200);
    step();
    offer(32'hE0843005, 32'h204);
    step();
    offer(32'hE0865007, 32'h208);
    step();
    chk("full_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 32'(in_ready), 0);
    step();
    chk("after_pop_head", out_pc, 32'h204);
    chk("after_pop_in_ready", 32'(in_ready), 1);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("pushpop_head", out_pc, 32'h208);
    offer(32'hE0887009, 32'h20C);
    step();
    in_valid = 1'b0;
    chk("refill_in_ready", 32'(in_ready), 0);
    chk("refill_head", out_pc, 32'h208);
    pop_one();
    chk("wrap_head", out_pc, 32'h20C);

    // flush with two queued and an offer present
    offer(32'hE1A00000, 32'h210);
    step();
    offer(32'hE1A01001, 32'h214);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    chk("flush_flags", 32'(flags), 4'b0100);
    // flush while in_ready=1, together with a flag write
    offer(32'hE1A02002, 32'h218);
    step();
    offer(32'hE1A03003, 32'h21C);
    flush     = 1'b1;
    flag_we   = 1'b1;
    flag_nzcv = 4'b1001;
    step();
    flush    = 1'b0;
    flag_we  = 1'b0;
    in_valid = 1'b0;
    chk("flush2_valid", 32'(out_valid), 0);
    chk("flush2_flags", 32'(flags), 4'b1001);

    // streaming: every condition code under changing flags
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      logic [31:0] kv;
      kv = 32'(k);
      offer({kv[3:0], 28'h0821003}, 32'h300 + 32'(4 * k));
      flag_we   = kv[0];
      flag_nzcv = 4'(k * 7 + 3);
      step();
    end
    in_valid = 1'b0;
    flag_we  = 1'b0;
    step();
    step();
    out_ready = 1'b0;

    // reset mid-stream
    offer(32'hE0821003, 32'h400);
    step();
    offer(32'hE0821003, 32'h404);
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_flags", 32'(flags), 0);
    chk("rst_mid_in_ready", 32'(in_ready), 1);
    step();
    rst = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
